// File: rtl/bsg_clk_gen_tag_pkg.sv
// Shared types and constants for the clock-generator tag sequencer.
package bsg_clk_gen_tag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAG_RST,
    ST_NODE_RST,
    ST_PROG,
    ST_RELEASE,
    ST_SEL,
    ST_MEASURE,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_LOAD,
    PH_BUSY,
    PH_GAP
  } phase_e;

  localparam int tag_rst_ones_c   = 32;
  localparam int tag_rst_zeros_c  = 8;
  localparam int gap_cycles_c     = 4;
  localparam int release_cycles_c = 16;

  function automatic int node_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

  // Length field must be able to express the ds payload (ds_width + reset bit)
  function automatic int len_width(input int ds_width);
    return $clog2(ds_width + 2);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    if (inc && (v != 16'hffff)) return v + 16'd1;
    return v;
  endfunction

endpackage

// File: rtl/bsg_clk_gen_tag_sequencer_if.sv
// Tag bus and clock-generator control signals between sequencer and generator.
interface bsg_clk_gen_tag_sequencer_if #(
  parameter int num_adgs_p = 1
);
  logic                    bsg_tag_en;
  logic                    bsg_tag_data;
  logic [2*num_adgs_p-1:0] bsg_clk_gen_sel;
  logic                    bsg_clk_gen_async_reset;
  logic                    bsg_clk_gen;

  modport master (
    output bsg_tag_en, bsg_tag_data, bsg_clk_gen_sel, bsg_clk_gen_async_reset,
    input  bsg_clk_gen
  );

  modport slave (
    input  bsg_tag_en, bsg_tag_data, bsg_clk_gen_sel, bsg_clk_gen_async_reset,
    output bsg_clk_gen
  );
endinterface

// File: rtl/bsg_tag_packet_tx.sv
// Serializes one bsg_tag packet LSB-first: start bit, node, data_not_reset, len, payload.
module bsg_tag_packet_tx #(
  parameter int nw = 2,
  parameter int lw = 4,
  parameter int pw = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [nw-1:0] node,
  input  logic          dnr,
  input  logic [lw-1:0] len,
  input  logic [pw-1:0] payload,
  output logic          line_bit,
  output logic          last_bit
);

  localparam int fw = 2 + nw + lw + pw;
  localparam int cw = $clog2(fw + 1);

  logic [fw-1:0] shift_reg;
  logic [cw-1:0] remain_reg;
  logic          busy_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_reg  <= '0;
      remain_reg <= '0;
      busy_reg   <= 1'b0;
    end else if (busy_reg) begin
      shift_reg <= shift_reg >> 1;
      if (remain_reg == '0) busy_reg <= 1'b0;
      else remain_reg <= remain_reg - cw'(1);
    end else if (load) begin
      // Payload bits above len are never shifted out, so no masking is needed
      shift_reg  <= {payload, len, dnr, node, 1'b1};
      remain_reg <= cw'(1 + nw + lw) + cw'(len);
      busy_reg   <= 1'b1;
    end
  end

  assign line_bit = busy_reg & shift_reg[0];
  assign last_bit = busy_reg & (remain_reg == '0);

endmodule

// File: rtl/bsg_clk_gen_tag_sequencer.sv
// Programs clock generators over bsg_tag, releases them, then measures the generated clock.
module bsg_clk_gen_tag_sequencer
  import bsg_clk_gen_tag_pkg::*;
#(
  parameter int                     fast_sim_p          = 1,
  parameter int                     num_adgs_p          = 1,
  parameter int                     osc_width_p         = 5,
  parameter int                     ds_width_p          = 8,
  parameter int                     tag_els_p           = 4,
  parameter int                     tag_node_base_p     = 0,
  parameter logic [osc_width_p-1:0] osc_final_val_p     = '0,
  parameter logic [ds_width_p-1:0]  ds_final_val_p      = '0,
  parameter logic [1:0]             clk_mux_final_val_p = 2'b00,
  parameter int                     measure_cycles_p    = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          start_i,
  bsg_clk_gen_tag_sequencer_if.master   tag_if,
  output logic [15:0]                   meas_count_o,
  output logic                          meas_valid_o,
  output logic                          done_o
);

  localparam int nw = node_width(tag_els_p);
  localparam int lw = len_width(ds_width_p);
  localparam int pw = (osc_width_p > ds_width_p + 1) ? osc_width_p : ds_width_p + 1;
  localparam int aw = (num_adgs_p > 1) ? $clog2(num_adgs_p) : 1;
  localparam logic [osc_width_p-1:0] osc_max_c = '1;

  state_e                  state_reg;
  phase_e                  phase_reg;
  logic [15:0]             cnt_reg;
  logic [aw-1:0]           adg_reg;
  logic [1:0]              sub_reg;
  logic [osc_width_p-1:0]  osc_reg;
  logic                    final_reg;
  logic                    en_reg;
  logic                    data_reg;
  logic [2*num_adgs_p-1:0] sel_reg;
  logic                    async_reset_reg;
  logic [2:0]              sync_reg;
  logic [15:0]             edge_cnt_reg;
  logic [15:0]             meas_count_reg;
  logic                    meas_valid_reg;
  logic                    done_reg;

  logic          pkt_load;
  logic          pkt_ds;
  logic          pkt_dnr;
  logic [nw-1:0] pkt_node;
  logic [lw-1:0] pkt_len;
  logic [pw-1:0] pkt_payload;
  logic [1:0]    last_sub;
  logic          tx_bit;
  logic          tx_last;
  logic          rise;

  // sync_reg[1:0] is the two-flop synchronizer, sync_reg[2] the previous sample
  assign rise = sync_reg[1] & ~sync_reg[2];

  // Packet fields: sub 0 addresses the osc node, sub 1/2 the ds node (reset bit set, then cleared)
  always_comb begin
    pkt_ds      = (sub_reg != 2'd0);
    pkt_dnr     = (state_reg == ST_PROG);
    pkt_node    = nw'(tag_node_base_p + 2 * int'(adg_reg) + (pkt_ds ? 1 : 0));
    pkt_len     = pkt_ds ? lw'(ds_width_p + 1) : lw'(osc_width_p);
    pkt_load    = ((state_reg == ST_NODE_RST) || (state_reg == ST_PROG)) && (phase_reg == PH_LOAD);
    last_sub    = (state_reg == ST_NODE_RST) ? 2'd1 : 2'd2;
    pkt_payload = '1;
    if (state_reg == ST_PROG) begin
      if (!pkt_ds) pkt_payload = pw'(osc_reg);
      else pkt_payload = pw'({ds_final_val_p, (sub_reg == 2'd1)});
    end
  end

  bsg_tag_packet_tx #(
    .nw (nw),
    .lw (lw),
    .pw (pw)
  ) tx (
    .clk      (clk_i),
    .reset_n  (reset_n_i),
    .load     (pkt_load),
    .node     (pkt_node),
    .dnr      (pkt_dnr),
    .len      (pkt_len),
    .payload  (pkt_payload),
    .line_bit (tx_bit),
    .last_bit (tx_last)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_reg       <= ST_IDLE;
      phase_reg       <= PH_LOAD;
      cnt_reg         <= '0;
      adg_reg         <= '0;
      sub_reg         <= '0;
      osc_reg         <= (fast_sim_p != 0) ? osc_final_val_p : '0;
      final_reg       <= (fast_sim_p != 0);
      en_reg          <= 1'b0;
      data_reg        <= 1'b0;
      sel_reg         <= '0;
      async_reset_reg <= 1'b1;
      sync_reg        <= '0;
      edge_cnt_reg    <= '0;
      meas_count_reg  <= '0;
      meas_valid_reg  <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[1:0], tag_if.bsg_clk_gen};
      meas_valid_reg <= 1'b0;
      data_reg       <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            state_reg <= ST_TAG_RST;
            en_reg    <= 1'b1;
            data_reg  <= 1'b1;
            cnt_reg   <= 16'd1;
          end
        end
        ST_TAG_RST: begin
          data_reg <= (cnt_reg < 16'(tag_rst_ones_c));
          cnt_reg  <= cnt_reg + 16'd1;
          if (cnt_reg == 16'(tag_rst_ones_c + tag_rst_zeros_c - 1)) begin
            state_reg <= ST_NODE_RST;
            phase_reg <= PH_LOAD;
            adg_reg   <= '0;
            sub_reg   <= '0;
          end
        end
        ST_NODE_RST, ST_PROG: begin
          data_reg <= tx_bit;
          case (phase_reg)
            PH_LOAD: phase_reg <= PH_BUSY;
            PH_BUSY: begin
              if (tx_last) begin
                phase_reg <= PH_GAP;
                cnt_reg   <= '0;
              end
            end
            PH_GAP: begin
              cnt_reg <= cnt_reg + 16'd1;
              if (cnt_reg == 16'(gap_cycles_c - 1)) begin
                phase_reg <= PH_LOAD;
                if (sub_reg != last_sub) begin
                  sub_reg <= sub_reg + 2'd1;
                end else begin
                  sub_reg <= '0;
                  if (adg_reg != aw'(num_adgs_p - 1)) begin
                    adg_reg <= adg_reg + aw'(1);
                  end else begin
                    adg_reg   <= '0;
                    cnt_reg   <= '0;
                    state_reg <= (state_reg == ST_NODE_RST) ? ST_PROG : ST_RELEASE;
                  end
                end
              end
            end
            default: phase_reg <= PH_LOAD;
          endcase
        end
        ST_RELEASE: begin
          async_reset_reg <= 1'b0;
          cnt_reg         <= cnt_reg + 16'd1;
          if (cnt_reg == 16'(release_cycles_c - 1)) state_reg <= ST_SEL;
        end
        ST_SEL: begin
          sel_reg      <= {num_adgs_p{clk_mux_final_val_p}};
          state_reg    <= ST_MEASURE;
          cnt_reg      <= '0;
          edge_cnt_reg <= '0;
        end
        ST_MEASURE: begin
          if (cnt_reg == 16'(measure_cycles_p - 1)) begin
            meas_count_reg <= sat_inc(edge_cnt_reg, rise);
            meas_valid_reg <= 1'b1;
            cnt_reg        <= '0;
            if (final_reg) begin
              state_reg <= ST_DONE;
            end else begin
              // Sweep continues without re-resetting nodes; the last step loads the final value
              state_reg <= ST_PROG;
              phase_reg <= PH_LOAD;
              if (osc_reg == osc_max_c) begin
                osc_reg   <= osc_final_val_p;
                final_reg <= 1'b1;
              end else begin
                osc_reg <= osc_reg + osc_width_p'(1);
              end
            end
          end else begin
            cnt_reg      <= cnt_reg + 16'd1;
            edge_cnt_reg <= sat_inc(edge_cnt_reg, rise);
          end
        end
        ST_DONE: done_reg <= 1'b1;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign tag_if.bsg_tag_en              = en_reg;
  assign tag_if.bsg_tag_data            = data_reg;
  assign tag_if.bsg_clk_gen_sel         = sel_reg;
  assign tag_if.bsg_clk_gen_async_reset = async_reset_reg;
  assign meas_count_o                   = meas_count_reg;
  assign meas_valid_o                   = meas_valid_reg;
  assign done_o                         = done_reg;

endmodule

// File: tb/tb_bsg_clk_gen_tag_sequencer.sv
// Bench: decodes the tag bitstream of a fast-sim and a sweeping sequencer against a packet scoreboard.
module tb_bsg_clk_gen_tag_sequencer;

  localparam int NW = 2;
  localparam int LW = 4;

  typedef struct {
    int node;
    int dnr;
    int len;
    int payload;
  } pkt_t;

  logic        clk;
  logic        rst_n_a, start_a, rst_n_b, start_b, gen_run;
  logic [15:0] count_a, count_b;
  logic        valid_a, valid_b, done_a, done_b;
  int          n_checks, n_fail;
  pkt_t        exp_q[$];

  bsg_clk_gen_tag_sequencer_if #(.num_adgs_p(1)) ifa ();
  bsg_clk_gen_tag_sequencer_if #(.num_adgs_p(1)) ifb ();

  bsg_clk_gen_tag_sequencer #(
    .fast_sim_p(1), .num_adgs_p(1), .osc_width_p(5), .ds_width_p(8), .tag_els_p(4),
    .tag_node_base_p(0), .osc_final_val_p(5'b10101), .ds_final_val_p(8'h00),
    .clk_mux_final_val_p(2'b00), .measure_cycles_p(64)
  ) dut_a (
    .clk_i(clk), .reset_n_i(rst_n_a), .start_i(start_a), .tag_if(ifa),
    .meas_count_o(count_a), .meas_valid_o(valid_a), .done_o(done_a)
  );

  bsg_clk_gen_tag_sequencer #(
    .fast_sim_p(0), .num_adgs_p(1), .osc_width_p(2), .ds_width_p(8), .tag_els_p(4),
    .tag_node_base_p(0), .osc_final_val_p(2'b10), .ds_final_val_p(8'hA5),
    .clk_mux_final_val_p(2'b01), .measure_cycles_p(64)
  ) dut_b (
    .clk_i(clk), .reset_n_i(rst_n_b), .start_i(start_b), .tag_if(ifb),
    .meas_count_o(count_b), .meas_valid_o(valid_b), .done_o(done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Generated clock for A toggles every clk cycle; B's stays frozen at 0
  initial begin
    ifa.bsg_clk_gen = 1'b0;
    ifb.bsg_clk_gen = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_run) ifa.bsg_clk_gen = ~ifa.bsg_clk_gen;
    end
  end

  function automatic logic f_data(input int w);
    return (w == 0) ? ifa.bsg_tag_data : ifb.bsg_tag_data;
  endfunction
  function automatic logic f_en(input int w);
    return (w == 0) ? ifa.bsg_tag_en : ifb.bsg_tag_en;
  endfunction
  function automatic logic f_async(input int w);
    return (w == 0) ? ifa.bsg_clk_gen_async_reset : ifb.bsg_clk_gen_async_reset;
  endfunction
  function automatic logic [1:0] f_sel(input int w);
    return (w == 0) ? ifa.bsg_clk_gen_sel : ifb.bsg_clk_gen_sel;
  endfunction
  function automatic logic [15:0] f_count(input int w);
    return (w == 0) ? count_a : count_b;
  endfunction
  function automatic logic f_valid(input int w);
    return (w == 0) ? valid_a : valid_b;
  endfunction
  function automatic logic f_done(input int w);
    return (w == 0) ? done_a : done_b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input int w, input string tag);
    check({tag, "_en"}, 32'(f_en(w)), 0);
    check({tag, "_data"}, 32'(f_data(w)), 0);
    check({tag, "_sel"}, 32'(f_sel(w)), 0);
    check({tag, "_async"}, 32'(f_async(w)), 1);
    check({tag, "_count"}, 32'(f_count(w)), 0);
    check({tag, "_valid"}, 32'(f_valid(w)), 0);
    check({tag, "_done"}, 32'(f_done(w)), 0);
    $display("reset dut%0d %s checked", w, tag);
  endtask

  task automatic push(input int node, input int dnr, input int len, input int payload);
    pkt_t p;
    p.node = node; p.dnr = dnr; p.len = len; p.payload = payload;
    exp_q.push_back(p);
  endtask

  task automatic preamble(input int w);
    int g, ones, zeros;
    bit seen;
    g = 0; seen = 0;
    while (g < 20) begin
      @(negedge clk);
      if (f_en(w) === 1'b1) begin seen = 1; break; end
      g++;
    end
    check("en_rise", 32'(seen), 1);
    ones = 0;
    while ((f_data(w) === 1'b1) && (ones < 100)) begin
      ones++;
      @(negedge clk);
    end
    zeros = (f_data(w) === 1'b0) ? 1 : 0;
    repeat (7) begin
      @(negedge clk);
      if (f_data(w) === 1'b0) zeros++;
    end
    check("tag_rst_ones", ones, 32);
    check("tag_rst_zeros", zeros, 8);
    $display("tag reset dut%0d ones=%0d zeros=%0d", w, ones, zeros);
  endtask

  task automatic recv(input int w, output pkt_t p, output bit ok);
    int g;
    p.node = 0; p.dnr = 0; p.len = 0; p.payload = 0;
    ok = 0; g = 0;
    while (g < 3000) begin
      @(negedge clk);
      if (f_data(w) === 1'b1) begin ok = 1; break; end
      g++;
    end
    if (!ok) return;
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      p.node |= int'(f_data(w)) << i;
    end
    @(negedge clk);
    p.dnr = int'(f_data(w));
    for (int i = 0; i < LW; i++) begin
      @(negedge clk);
      p.len |= int'(f_data(w)) << i;
    end
    for (int i = 0; i < p.len; i++) begin
      @(negedge clk);
      p.payload |= int'(f_data(w)) << i;
    end
  endtask

  task automatic drain(input int w, input int n, input logic exp_async);
    pkt_t e, p;
    bit ok;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      recv(w, p, ok);
      check("pkt_arrived", 32'(ok), 1);
      if (!ok) return;
      check("pkt_node", p.node, e.node);
      check("pkt_dnr", p.dnr, e.dnr);
      check("pkt_len", p.len, e.len);
      check("pkt_payload", p.payload, e.payload);
      check("pkt_async_reset", 32'(f_async(w)), 32'(exp_async));
      $display("packet dut%0d node=%0d dnr=%0d len=%0d payload=0x%0h", w, p.node, p.dnr, p.len, p.payload);
    end
  endtask

  task automatic wait_meas(input int w, input int exp_cnt, input logic [1:0] exp_sel, input logic exp_done);
    int g;
    bit seen;
    g = 0; seen = 0;
    while (g < 600) begin
      @(negedge clk);
      if (f_valid(w) === 1'b1) begin seen = 1; break; end
      g++;
    end
    check("meas_valid_seen", 32'(seen), 1);
    if (!seen) return;
    check("meas_count", 32'(f_count(w)), exp_cnt);
    check("meas_async_reset", 32'(f_async(w)), 0);
    check("meas_sel", 32'(f_sel(w)), 32'(exp_sel));
    @(negedge clk);
    check("meas_valid_pulse", 32'(f_valid(w)), 0);
    check("done_after_meas", 32'(f_done(w)), 32'(exp_done));
    $display("measure dut%0d count=%0d sel=%0b done=%0b", w, f_count(w), f_sel(w), f_done(w));
  endtask

  task automatic push_fast_a();
    push(0, 0, 5, 'h1f);
    push(1, 0, 9, 'h1ff);
    push(0, 1, 5, 21);
    push(1, 1, 9, 'h001);
    push(1, 1, 9, 'h000);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n_a = 1'b0; rst_n_b = 1'b0; start_a = 1'b0; start_b = 1'b0; gen_run = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset(0, "reset_a");
    check_reset(1, "reset_b");
    rst_n_a = 1'b1; rst_n_b = 1'b1; gen_run = 1'b1;

    // Idle with start low: line stays quiet
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_en", 32'(f_en(0)), 0);
      check("idle_data", 32'(f_data(0)), 0);
      check("idle_done", 32'(f_done(0)), 0);
    end
    $display("idle dut0 100 cycles checked");

    // Fast-sim run on A
    push_fast_a();
    start_a = 1'b1;
    preamble(0);
    start_a = 1'b0;
    drain(0, 5, 1'b1);
    wait_meas(0, 32, 2'b00, 1'b1);
    start_a = 1'b1;
    repeat (10) @(negedge clk);
    check("done_sticky", 32'(f_done(0)), 1);
    check("done_en", 32'(f_en(0)), 1);
    check("done_data", 32'(f_data(0)), 0);
    start_a = 1'b0;
    rst_n_a = 1'b0;
    @(negedge clk);
    check_reset(0, "reset_after_done");
    rst_n_a = 1'b1;

    // Reset in the middle of PROG, then a restart must replay the same stream
    push_fast_a();
    start_a = 1'b1;
    preamble(0);
    start_a = 1'b0;
    drain(0, 3, 1'b1);
    rst_n_a = 1'b0;
    @(negedge clk);
    check_reset(0, "reset_mid_prog");
    rst_n_a = 1'b1;
    exp_q.delete();
    push_fast_a();
    start_a = 1'b1;
    preamble(0);
    start_a = 1'b0;
    drain(0, 5, 1'b1);
    wait_meas(0, 32, 2'b00, 1'b1);

    // Sweep run on B with frozen generated clock
    push(0, 0, 2, 'h3);
    push(1, 0, 9, 'h1ff);
    start_b = 1'b1;
    preamble(1);
    start_b = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push(0, 1, 2, (k < 4) ? k : 2);
      push(1, 1, 9, 'h14b);
      push(1, 1, 9, 'h14a);
      drain(1, exp_q.size(), (k == 0));
      wait_meas(1, 0, 2'b01, (k == 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
